rc4_key_search: RTL and testbench
=================================

RC4_KEY_SEARCH -- requirements
Module: rc4_key_search

Interface
REQ-001 SHALL have parameter KEY_WIDTH, default 24, secret-key width in bits (multiple of 8).
REQ-002 SHALL have parameter KEY_FIRST, default 0, first key tried.
REQ-003 SHALL have parameter KEY_LAST, default 24'h3FFFFF, last key allowed.
REQ-004 SHALL have parameter KEY_STRIDE, default 1, key increment (partitions the key space across parallel cores).
REQ-005 SHALL have parameter MSG_LEN, default 32, decrypted bytes per key.
REQ-006 SHALL have ports, in this order:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a search.
- stop  in  1  abort the search (another core succeeded).
- init_start  out  1  request S-array init.
- init_finish  in  1  init-done pulse.
- shuffle_start  out  1  request KSA shuffle.
- shuffle_finish  in  1  shuffle-done pulse.
- dec_start  out  1  request PRGA decrypt.
- dec_finish  in  1  decrypt-done pulse.
- dec_valid  in  1  dec_byte is valid this cycle.
- dec_byte  in  8  decrypted byte stream.
- dec_abort  out  1  abort the decrypter early.
- key  out  KEY_WIDTH  current key.
- keys_tried  out  KEY_WIDTH  number of keys fully evaluated.
- busy, found, exhausted, stopped  out  1 each  status.

Function
REQ-007 SHALL implement states IDLE, INIT, SHUFFLE, DECRYPT, CHECK, NEXT_KEY, FOUND, EXHAUSTED, STOPPED.
REQ-008 SHALL, on start=1 in IDLE/FOUND/EXHAUSTED/STOPPED, load key=KEY_FIRST, clear keys_tried and the check flag, and go to INIT next cycle.
REQ-009 SHALL ignore start while busy (INIT..NEXT_KEY).
REQ-010 SHALL drive init_start/shuffle_start/dec_start high as levels decoded directly from the state register, each high only in INIT/SHUFFLE/DECRYPT respectively.
REQ-011 SHALL advance INIT->SHUFFLE, SHUFFLE->DECRYPT and DECRYPT->CHECK on the cycle after the matching *_finish is sampled high.
REQ-012 SHALL re-run INIT for every key.
REQ-013 SHALL treat a byte as legal iff it is 8'h20 or in 8'h61..8'h7A.
REQ-014 SHALL count dec_valid bytes and set a sticky bad flag on any illegal byte; bytes beyond MSG_LEN are ignored.
REQ-015 SHALL, in CHECK, go to FOUND if bad=0 and count==MSG_LEN, otherwise go to NEXT_KEY; CHECK lasts exactly one cycle.
REQ-016 SHALL, in NEXT_KEY, increment keys_tried, then go to EXHAUSTED if KEY_LAST-key < KEY_STRIDE, else set key+=KEY_STRIDE, clear count/bad and go to INIT; no overflow or wrap is permitted.
REQ-017 SHALL hold key at the winning/last value in FOUND/EXHAUSTED/STOPPED, with found/exhausted/stopped high only in the respective state.
REQ-018 SHALL, on stop=1 in any busy state, go to STOPPED next cycle with all *_start low; stop has priority over any *_finish in the same cycle.
REQ-019 SHALL evaluate dec_valid before dec_finish when both are high in the same cycle.
REQ-020 SHALL drive busy high in INIT..NEXT_KEY only.

Reset
REQ-021 SHALL, on reset=0, asynchronously enter IDLE with key=KEY_FIRST and all other outputs and counters 0.
REQ-022 SHALL, on reset mid-search, discard all progress; restarting requires a fresh start.

Configuration
REQ-023 SHALL, with RC4_EARLY_ABORT_EN defined, assert dec_abort for one cycle on the first illegal byte and then go to NEXT_KEY without waiting for dec_finish.
REQ-024 SHALL, without RC4_EARLY_ABORT_EN, tie dec_abort to 0 and always wait for dec_finish.

Structure
REQ-025 SHALL take the state enum, ASCII bounds (8'h20, 8'h61, 8'h7A) and parameter defaults from shared package rc4_pkg.
REQ-026 SHALL place byte legality, count and the sticky bad flag in sub-module rc4_ascii_check.

Verification
REQ-027 SHALL show: engine model decrypting legal text at key 24'h000003 with KEY_FIRST=0 -> found=1, key=3, keys_tried=4.
REQ-028 SHALL show: KEY_FIRST=0, KEY_LAST=7, KEY_STRIDE=4, no key legal -> keys 0,4 tried, exhausted=1, key=4, keys_tried=2.
REQ-029 SHALL show: stop pulsed in the same cycle as shuffle_finish -> STOPPED next cycle, dec_start never asserted.
REQ-030 SHALL show: reset=0 during DECRYPT -> all outputs 0 immediately, and start then restarts at KEY_FIRST.
REQ-031 SHALL show: byte 8'h41 at index 5 with RC4_EARLY_ABORT_EN -> dec_abort pulse, next key begins with no dec_finish; without the macro -> waits for dec_finish, then NEXT_KEY.
REQ-032 SHALL show: start asserted while busy -> key and keys_tried unaffected.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 key-search engine: state encoding, ASCII bounds, parameter defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   rc4_state_e      - key-search FSM states
//   ASCII_*          - bounds of the plaintext alphabet (space, 'a'..'z')
//   RC4_*_DEF        - default values for the rc4_key_search parameters
//   rc4_is_legal()   - plaintext byte legality test
package rc4_pkg;

    localparam int RC4_KEY_WIDTH_DEF  = 24;
    localparam int RC4_KEY_FIRST_DEF  = 0;
    localparam int RC4_KEY_LAST_DEF   = 32'h003F_FFFF;
    localparam int RC4_KEY_STRIDE_DEF = 1;
    localparam int RC4_MSG_LEN_DEF    = 32;

    localparam logic [7:0] ASCII_SPACE   = 8'h20;
    localparam logic [7:0] ASCII_LOWER_A = 8'h61;
    localparam logic [7:0] ASCII_LOWER_Z = 8'h7A;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        SHUFFLE,
        DECRYPT,
        CHECK,
        NEXT_KEY,
        FOUND,
        EXHAUSTED,
        STOPPED
    } rc4_state_e;

    function automatic logic rc4_is_legal(input logic [7:0] b);
        return (b == ASCII_SPACE) || ((b >= ASCII_LOWER_A) && (b <= ASCII_LOWER_Z));
    endfunction

endpackage

// File: rtl/rc4_ascii_check.sv
// Plaintext checker: counts decrypted bytes and keeps a sticky flag for any non-alphabet byte.
// Latency: count/bad reflect a byte on the cycle after dec_valid; first_bad is combinational.
// Backpressure: none; every dec_valid byte is consumed, bytes past MSG_LEN are dropped.
//
// Ports:
//   clk, reset      - clock, async active-low reset
//   clr             - synchronous clear of count and bad
//   en              - accept bytes only while set (engine in DECRYPT)
//   dec_valid/byte  - decrypted byte stream
//   count           - bytes accepted so far (saturates at MSG_LEN)
//   bad             - sticky: an accepted byte was illegal
//   first_bad       - this cycle carries the first illegal accepted byte
module rc4_ascii_check
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = RC4_MSG_LEN_DEF,
    parameter int CNT_W   = $clog2(MSG_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             dec_valid,
    input  logic [7:0]       dec_byte,
    output logic [CNT_W-1:0] count,
    output logic             bad,
    output logic             first_bad
);

    logic take;
    logic legal;

    // Once MSG_LEN bytes are in, later bytes neither count nor poison the flag.
    assign take      = en && dec_valid && (count < CNT_W'(MSG_LEN));
    assign legal     = rc4_is_legal(dec_byte);
    assign first_bad = take && !legal && !bad;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            bad   <= 1'b0;
        end else if (clr) begin
            count <= '0;
            bad   <= 1'b0;
        end else if (take) begin
            count <= count + 1'b1;
            if (!legal) begin
                bad <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/rc4_key_search.sv
// RC4 brute-force key sequencer: steps keys through init/shuffle/decrypt engines and checks plaintext.
// Latency: one cycle per state hop; each *_finish/stop acts on the state one cycle later.
// Backpressure: engines are handshaked by level start / pulse finish; stop aborts from any busy state.
//
// Ports:
//   clk, reset                     - clock, async active-low reset
//   start / stop                   - begin a search / abort it (another core won)
//   init_*, shuffle_*, dec_*       - engine start levels and done pulses, decrypted byte stream
//   dec_abort                      - one-cycle early-abort request to the decrypter
//   key, keys_tried                - current key, keys fully evaluated
//   busy, found, exhausted, stopped - status
// Build option: RC4_EARLY_ABORT_EN - abandon a key on its first illegal byte instead of waiting
//   for dec_finish; without it dec_abort is tied low.
module rc4_key_search
    import rc4_pkg::*;
#(
    parameter int                   KEY_WIDTH  = RC4_KEY_WIDTH_DEF,
    parameter logic [KEY_WIDTH-1:0] KEY_FIRST  = KEY_WIDTH'(RC4_KEY_FIRST_DEF),
    parameter logic [KEY_WIDTH-1:0] KEY_LAST   = KEY_WIDTH'(RC4_KEY_LAST_DEF),
    parameter logic [KEY_WIDTH-1:0] KEY_STRIDE = KEY_WIDTH'(RC4_KEY_STRIDE_DEF),
    parameter int                   MSG_LEN    = RC4_MSG_LEN_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    output logic                 init_start,
    input  logic                 init_finish,
    output logic                 shuffle_start,
    input  logic                 shuffle_finish,
    output logic                 dec_start,
    input  logic                 dec_finish,
    input  logic                 dec_valid,
    input  logic [7:0]           dec_byte,
    output logic                 dec_abort,
    output logic [KEY_WIDTH-1:0] key,
    output logic [KEY_WIDTH-1:0] keys_tried,
    output logic                 busy,
    output logic                 found,
    output logic                 exhausted,
    output logic                 stopped
);

    localparam int CNT_W = $clog2(MSG_LEN + 1);

`ifdef RC4_EARLY_ABORT_EN
    localparam bit EARLY_ABORT = 1'b1;
`else
    localparam bit EARLY_ABORT = 1'b0;
`endif

    rc4_state_e       state;
    rc4_state_e       state_nxt;
    logic             key_load;
    logic             key_step;
    logic             tried_inc;
    logic             chk_clr;
    logic [CNT_W-1:0] count;
    logic             bad;
    logic             first_bad;

    rc4_ascii_check #(
        .MSG_LEN (MSG_LEN),
        .CNT_W   (CNT_W)
    ) u_check (
        .clk       (clk),
        .reset     (reset),
        .clr       (chk_clr),
        .en        (state == DECRYPT),
        .dec_valid (dec_valid),
        .dec_byte  (dec_byte),
        .count     (count),
        .bad       (bad),
        .first_bad (first_bad)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath strobes; stop outranks every finish pulse.
    always_comb begin
        state_nxt = state;
        key_load  = 1'b0;
        key_step  = 1'b0;
        tried_inc = 1'b0;
        chk_clr   = 1'b0;
        case (state)
            IDLE, FOUND, EXHAUSTED, STOPPED: begin
                if (start) begin
                    state_nxt = INIT;
                    key_load  = 1'b1;
                    chk_clr   = 1'b1;
                end
            end
            INIT: begin
                if (stop)             state_nxt = STOPPED;
                else if (init_finish) state_nxt = SHUFFLE;
            end
            SHUFFLE: begin
                if (stop)                state_nxt = STOPPED;
                else if (shuffle_finish) state_nxt = DECRYPT;
            end
            DECRYPT: begin
                // The checker consumes a byte arriving with dec_finish before CHECK reads it.
                if (stop)                            state_nxt = STOPPED;
                else if (EARLY_ABORT && first_bad)   state_nxt = NEXT_KEY;
                else if (dec_finish)                 state_nxt = CHECK;
            end
            CHECK: begin
                if (stop) begin
                    state_nxt = STOPPED;
                end else if (!bad && (count == CNT_W'(MSG_LEN))) begin
                    // The winning key is also a fully evaluated key.
                    state_nxt = FOUND;
                    tried_inc = 1'b1;
                end else begin
                    state_nxt = NEXT_KEY;
                end
            end
            NEXT_KEY: begin
                if (stop) begin
                    state_nxt = STOPPED;
                end else begin
                    tried_inc = 1'b1;
                    // Subtraction form keeps the bound check free of key overflow.
                    if ((KEY_LAST - key) < KEY_STRIDE) begin
                        state_nxt = EXHAUSTED;
                    end else begin
                        state_nxt = INIT;
                        key_step  = 1'b1;
                        chk_clr   = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the state register only
    always_comb begin
        init_start    = (state == INIT);
        shuffle_start = (state == SHUFFLE);
        dec_start     = (state == DECRYPT);
        busy          = (state == INIT) || (state == SHUFFLE) || (state == DECRYPT) ||
                        (state == CHECK) || (state == NEXT_KEY);
        found         = (state == FOUND);
        exhausted     = (state == EXHAUSTED);
        stopped       = (state == STOPPED);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key        <= KEY_FIRST;
            keys_tried <= '0;
        end else if (key_load) begin
            key        <= KEY_FIRST;
            keys_tried <= '0;
        end else begin
            if (key_step) begin
                key <= key + KEY_STRIDE;
            end
            if (tried_inc) begin
                keys_tried <= keys_tried + 1'b1;
            end
        end
    end

`ifdef RC4_EARLY_ABORT_EN
    // High during the NEXT_KEY cycle that follows the first illegal byte.
    logic abort_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            abort_q <= 1'b0;
        end else begin
            abort_q <= (state == DECRYPT) && !stop && first_bad;
        end
    end
    assign dec_abort = abort_q;
`else
    assign dec_abort = 1'b0;
`endif

endmodule

// File: tb/tb_rc4_key_search.sv
// Directed bench for rc4_key_search: two instances (stride 1 full range, stride 4 over 0..7).
// Expected key sequence per search is queued up front and popped each time the DUT enters INIT.
module tb_rc4_key_search;

    localparam int MSG = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start_i[2], stop_i[2];
    logic        init_finish[2], shuffle_finish[2], dec_finish[2], dec_valid[2];
    logic [7:0]  dec_byte[2];
    logic        init_start[2], shuffle_start[2], dec_start[2], dec_abort[2];
    logic        busy[2], found[2], exhausted[2], stopped[2];
    logic [23:0] key[2], keys_tried[2];

    int vectors = 0;
    int misses  = 0;
    logic [23:0] exp_keys[$];

    rc4_key_search #(.KEY_WIDTH(24), .KEY_FIRST(24'd0), .KEY_LAST(24'h3FFFFF),
                     .KEY_STRIDE(24'd1), .MSG_LEN(MSG)) dut_a (
        .clk(clk), .reset(rst_n), .start(start_i[0]), .stop(stop_i[0]),
        .init_start(init_start[0]), .init_finish(init_finish[0]),
        .shuffle_start(shuffle_start[0]), .shuffle_finish(shuffle_finish[0]),
        .dec_start(dec_start[0]), .dec_finish(dec_finish[0]),
        .dec_valid(dec_valid[0]), .dec_byte(dec_byte[0]), .dec_abort(dec_abort[0]),
        .key(key[0]), .keys_tried(keys_tried[0]), .busy(busy[0]), .found(found[0]),
        .exhausted(exhausted[0]), .stopped(stopped[0]));

    rc4_key_search #(.KEY_WIDTH(24), .KEY_FIRST(24'd0), .KEY_LAST(24'd7),
                     .KEY_STRIDE(24'd4), .MSG_LEN(MSG)) dut_b (
        .clk(clk), .reset(rst_n), .start(start_i[1]), .stop(stop_i[1]),
        .init_start(init_start[1]), .init_finish(init_finish[1]),
        .shuffle_start(shuffle_start[1]), .shuffle_finish(shuffle_finish[1]),
        .dec_start(dec_start[1]), .dec_finish(dec_finish[1]),
        .dec_valid(dec_valid[1]), .dec_byte(dec_byte[1]), .dec_abort(dec_abort[1]),
        .key(key[1]), .keys_tried(keys_tried[1]), .busy(busy[1]), .found(found[1]),
        .exhausted(exhausted[1]), .stopped(stopped[1]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            misses++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic stage_sig(input int d, input int w);
        case (w)
            0:       return init_start[d];
            1:       return shuffle_start[d];
            default: return dec_start[d];
        endcase
    endfunction

    function automatic logic [7:0] legal_byte(input int i);
        case (i % 4)
            0:       return 8'h61 + 8'(i);
            1:       return 8'h7A;
            2:       return 8'h20;
            default: return 8'h6D;
        endcase
    endfunction

    task automatic wait_start(input int d, input int w, input string tag);
        logic seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (stage_sig(d, w)) seen = 1'b1;
            else tick();
        end
        chk({tag, " reached"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_idle(input int d, input string tag);
        logic seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (!busy[d]) seen = 1'b1;
            else tick();
        end
        chk({tag, " idle reached"}, 32'(seen), 32'd1);
    endtask

    task automatic pop_key(input int d, input string tag);
        if (exp_keys.size() == 0) chk({tag, " scoreboard empty"}, 32'd1, 32'd0);
        else chk({tag, " key at init"}, 32'(key[d]), 32'(exp_keys.pop_front()));
    endtask

    // One key: init, shuffle, then nbytes decrypted bytes with an optional bad byte at bad_idx.
    // extra_bad appends an illegal byte beyond the message, carrying dec_finish.
    task automatic run_key(input int d, input int bad_idx, input logic [7:0] bad_val,
                           input int nbytes, input logic extra_bad);
        wait_start(d, 0, "init");
        pop_key(d, "run");
        init_finish[d] = 1'b1; tick(); init_finish[d] = 1'b0;
        wait_start(d, 1, "shuffle");
        shuffle_finish[d] = 1'b1; tick(); shuffle_finish[d] = 1'b0;
        wait_start(d, 2, "decrypt");
        for (int i = 0; i < nbytes; i++) begin
            dec_valid[d]  = 1'b1;
            dec_byte[d]   = (i == bad_idx) ? bad_val : legal_byte(i);
            dec_finish[d] = (i == nbytes - 1) && !extra_bad;
            tick();
`ifdef RC4_EARLY_ABORT_EN
            if (i == bad_idx) begin
                chk("early dec_abort", 32'(dec_abort[d]), 32'd1);
                chk("early no dec_start", 32'(dec_start[d]), 32'd0);
                dec_valid[d]  = 1'b0;
                dec_finish[d] = 1'b0;
                return;
            end
`else
            if (i == bad_idx && i < nbytes - 1) begin
                chk("waits for finish", 32'(dec_start[d]), 32'd1);
                chk("dec_abort tied low", 32'(dec_abort[d]), 32'd0);
            end
`endif
        end
        if (extra_bad) begin
            dec_valid[d] = 1'b1; dec_byte[d] = 8'h41; dec_finish[d] = 1'b1;
            tick();
        end
        dec_valid[d]  = 1'b0;
        dec_finish[d] = 1'b0;
        chk("check state busy", 32'(busy[d]), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dec_seen;
        for (int d = 0; d < 2; d++) begin
            start_i[d] = 0; stop_i[d] = 0; init_finish[d] = 0; shuffle_finish[d] = 0;
            dec_finish[d] = 0; dec_valid[d] = 0; dec_byte[d] = 8'h00;
        end
        #12;
        chk("reset key a", 32'(key[0]), 32'd0);
        chk("reset tried a", 32'(keys_tried[0]), 32'd0);
        chk("reset busy a", 32'(busy[0]), 32'd0);
        chk("reset status a", {29'd0, found[0], exhausted[0], stopped[0]}, 32'd0);
        chk("reset starts a", {29'd0, init_start[0], shuffle_start[0], dec_start[0]}, 32'd0);
        chk("reset dec_abort a", 32'(dec_abort[0]), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Search finds key 3: key 0 bad first byte, key 1 short, key 2 'A' at index 5,
        // key 3 legal with an illegal byte past the message end.
        exp_keys.push_back(24'd0); exp_keys.push_back(24'd1);
        exp_keys.push_back(24'd2); exp_keys.push_back(24'd3);
        start_i[0] = 1'b1; tick(); start_i[0] = 1'b0;
        chk("busy after start", 32'(busy[0]), 32'd1);
        run_key(0, 0, 8'h7B, MSG, 1'b0);
        run_key(0, -1, 8'h00, MSG - 1, 1'b0);
        tick();                             // NEXT_KEY
        start_i[0] = 1'b1; tick(); start_i[0] = 1'b0;
        chk("start while busy key", 32'(key[0]), 32'd2);
        chk("start while busy tried", 32'(keys_tried[0]), 32'd2);
        run_key(0, 5, 8'h41, MSG, 1'b0);
        run_key(0, -1, 8'h00, MSG, 1'b1);
        tick();                             // CHECK -> FOUND
        chk("found", 32'(found[0]), 32'd1);
        chk("found key", 32'(key[0]), 32'd3);
        chk("found tried", 32'(keys_tried[0]), 32'd4);
        chk("found not busy", 32'(busy[0]), 32'd0);
        chk("scoreboard drained", 32'(exp_keys.size()), 32'd0);

        // stop together with shuffle_finish: stop wins, decrypt never starts.
        exp_keys.push_back(24'd0);
        start_i[0] = 1'b1; tick(); start_i[0] = 1'b0;
        wait_start(0, 0, "stop init");
        pop_key(0, "stop");
        init_finish[0] = 1'b1; tick(); init_finish[0] = 1'b0;
        wait_start(0, 1, "stop shuffle");
        shuffle_finish[0] = 1'b1; stop_i[0] = 1'b1;
        tick();
        shuffle_finish[0] = 1'b0; stop_i[0] = 1'b0;
        chk("stopped", 32'(stopped[0]), 32'd1);
        chk("stopped not busy", 32'(busy[0]), 32'd0);
        chk("stopped starts low", {29'd0, init_start[0], shuffle_start[0], dec_start[0]}, 32'd0);
        dec_seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (dec_start[0]) dec_seen++;
            tick();
        end
        chk("dec_start never", 32'(dec_seen), 32'd0);

        // Reset during DECRYPT of key 1, then a fresh start from key 0.
        exp_keys.push_back(24'd0); exp_keys.push_back(24'd1);
        start_i[0] = 1'b1; tick(); start_i[0] = 1'b0;
        run_key(0, 0, 8'h7B, MSG, 1'b0);
        wait_start(0, 0, "rst init");
        pop_key(0, "rst");
        init_finish[0] = 1'b1; tick(); init_finish[0] = 1'b0;
        wait_start(0, 1, "rst shuffle");
        shuffle_finish[0] = 1'b1; tick(); shuffle_finish[0] = 1'b0;
        wait_start(0, 2, "rst decrypt");
        dec_valid[0] = 1'b1; dec_byte[0] = 8'h61; tick();
        dec_byte[0] = 8'h62; tick();
        dec_valid[0] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async rst dec_start", 32'(dec_start[0]), 32'd0);
        chk("async rst busy", 32'(busy[0]), 32'd0);
        chk("async rst key", 32'(key[0]), 32'd0);
        chk("async rst tried", 32'(keys_tried[0]), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle after rst", 32'(busy[0]), 32'd0);
        exp_keys.push_back(24'd0);
        start_i[0] = 1'b1; tick(); start_i[0] = 1'b0;
        run_key(0, -1, 8'h00, MSG, 1'b0);
        tick();
        chk("restart found", 32'(found[0]), 32'd1);
        chk("restart key", 32'(key[0]), 32'd0);
        chk("restart tried", 32'(keys_tried[0]), 32'd1);

        // Stride 4 over 0..7: keys 0 and 4 both fail, search exhausts at key 4.
        chk("b reset key", 32'(key[1]), 32'd0);
        exp_keys.push_back(24'd0); exp_keys.push_back(24'd4);
        start_i[1] = 1'b1; tick(); start_i[1] = 1'b0;
        run_key(1, 2, 8'h60, MSG, 1'b0);
        run_key(1, MSG - 1, 8'h5B, MSG, 1'b0);
        wait_idle(1, "b");
        chk("b exhausted", 32'(exhausted[1]), 32'd1);
        chk("b found", 32'(found[1]), 32'd0);
        chk("b key", 32'(key[1]), 32'd4);
        chk("b tried", 32'(keys_tried[1]), 32'd2);
        chk("b scoreboard drained", 32'(exp_keys.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
